imem_boot_sequencer: RTL and testbench

- Owns the instruction-memory write port (InsWrEN/InsWrAddr/InsDataIn) of MIPS_CPU and the CPU's nclear hold.
- Accepts a valid/ready word stream from a host loader and writes the words to consecutive instruction addresses.
- Releases the CPU only after the image is fully loaded (and optionally checksum-verified).
- Replaces the hand-timed instruction-write plus nclear sequencing with a deterministic state machine.

---
 rtl/imem_boot_sequencer.sv | 162 ++++++++++++++++
 tb/tb_imem_boot_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_sequencer.sv
// Loads a host word stream into instruction memory, then releases the CPU via nclear.
// Optional checksum word after the image: define IMEM_BOOT_CHECKSUM_EN.
module imem_boot_sequencer #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              nRST,
   input  logic              start,
   input  logic [ADDR_W:0]   load_len,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              InsWrEN,
   output logic [ADDR_W-1:0] InsWrAddr,
   output logic [DATA_W-1:0] InsDataIn,
   output logic              nclear,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
`ifdef IMEM_BOOT_CHECKSUM_EN
      S_CHK   = 3'd2,
`endif
      S_DRAIN = 3'd3,
      S_RUN   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]     rem_q, rem_d;
   logic                wen_q, wen_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
   logic [DATA_W-1:0]   sum_q, sum_d;
`endif

   logic accept;
   logic len_ok;

   assign len_ok = (load_len != '0) && (load_len <= LEN_MAX);
   assign accept = s_valid && s_ready;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rem_d    = rem_q;
      wen_d    = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      done_d   = done_q;
      err_d    = err_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_d    = sum_q;
`endif
      case (state_q)
         S_IDLE, S_RUN: begin
            if (start) begin
               if (len_ok) begin
                  state_d  = S_LOAD;
                  wr_ptr_d = base_addr;
                  rem_d    = load_len;
                  err_d    = 1'b0;
                  done_d   = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                  sum_d    = '0;
`endif
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (accept) begin
               wen_d    = 1'b1;
               waddr_d  = wr_ptr_q;
               wdata_d  = s_data;
               // DEPTH == 2**ADDR_W, so natural overflow wraps the pointer.
               wr_ptr_d = wr_ptr_q + 1'b1;
               rem_d    = rem_q - 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
               sum_d    = sum_q + s_data;
               if (rem_q == 1) state_d = S_CHK;
`else
               if (rem_q == 1) state_d = S_DRAIN;
`endif
            end
         end
`ifdef IMEM_BOOT_CHECKSUM_EN
         S_CHK: begin
            if (accept) begin
               if (s_data == sum_q) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_IDLE;
                  err_d   = 1'b1;
               end
            end
         end
`endif
         S_DRAIN: begin
            state_d = S_RUN;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rem_q    <= '0;
         wen_q    <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
         sum_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rem_q    <= rem_d;
         wen_q    <= wen_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         done_q   <= done_d;
         err_q    <= err_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
         sum_q    <= sum_d;
`endif
      end
   end

`ifdef IMEM_BOOT_CHECKSUM_EN
   assign s_ready = (state_q == S_LOAD) || (state_q == S_CHK);
   assign busy    = (state_q == S_LOAD) || (state_q == S_CHK) || (state_q == S_DRAIN);
`else
   assign s_ready = (state_q == S_LOAD);
   assign busy    = (state_q == S_LOAD) || (state_q == S_DRAIN);
`endif
   assign nclear    = (state_q == S_RUN);
   assign InsWrEN   = wen_q;
   assign InsWrAddr = waddr_q;
   assign InsDataIn = wdata_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Directed bench for imem_boot_sequencer with a write scoreboard (address, data, cycle).
module tb_imem_boot_sequencer;

   logic        clk = 1'b0;
   logic        nRST;
   logic        start;
   logic [5:0]  load_len;
   logic [4:0]  base_addr;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic        InsWrEN;
   logic [4:0]  InsWrAddr;
   logic [31:0] InsDataIn;
   logic        nclear;
   logic        busy;
   logic        done;
   logic        err;

   imem_boot_sequencer dut (
      .clk(clk), .nRST(nRST), .start(start), .load_len(load_len),
      .base_addr(base_addr), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .InsWrEN(InsWrEN), .InsWrAddr(InsWrAddr),
      .InsDataIn(InsDataIn), .nclear(nclear), .busy(busy),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      int          c;
   } wr_t;
   wr_t exp_q[$];

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] sum;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (nRST === 1'b1 && InsWrEN === 1'b1) begin
         chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 64'(InsWrAddr), 64'(e.a));
            chk("wr_data", 64'(InsDataIn), 64'(e.d));
            chk("wr_cycle", 64'(cyc), 64'(e.c));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [5:0] len, input logic [4:0] base);
      start     = 1'b1;
      load_len  = len;
      base_addr = base;
      tick();
      start = 1'b0;
      sum   = 32'd0;
   endtask

   task automatic send_word(input logic [31:0] w, input logic [4:0] a, input bit wr);
      s_valid = 1'b1;
      s_data  = w;
      chk("s_ready_load", 64'(s_ready), 64'd1);
      if (wr) begin
         exp_q.push_back('{a: a, d: w, c: cyc + 1});
         sum = sum + w;
      end
      tick();
   endtask

   task automatic end_load();
`ifdef IMEM_BOOT_CHECKSUM_EN
      send_word(sum, 5'd0, 1'b0);
`endif
      s_valid = 1'b0;
      chk("drain_busy", 64'(busy), 64'd1);
      chk("drain_nclear", 64'(nclear), 64'd0);
      chk("drain_s_ready", 64'(s_ready), 64'd0);
      tick();
      chk("run_nclear", 64'(nclear), 64'd1);
      chk("run_done", 64'(done), 64'd1);
      chk("run_busy", 64'(busy), 64'd0);
      chk("run_err", 64'(err), 64'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
      chk({tag, "_wen"}, 64'(InsWrEN), 64'd0);
      chk({tag, "_waddr"}, 64'(InsWrAddr), 64'd0);
      chk({tag, "_wdata"}, 64'(InsDataIn), 64'd0);
      chk({tag, "_nclear"}, 64'(nclear), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
   endtask

   initial begin
      nRST      = 1'b0;
      start     = 1'b0;
      load_len  = 6'd0;
      base_addr = 5'd0;
      s_valid   = 1'b0;
      s_data    = 32'd0;
      sum       = 32'd0;
      #12;
      chk_reset_vals("reset");
      @(negedge clk);
      nRST = 1'b1;
      tick();

      // Illegal length in IDLE
      do_start(6'd0, 5'd5);
      chk("idle_badlen_err", 64'(err), 64'd1);
      chk("idle_badlen_busy", 64'(busy), 64'd0);
      chk("idle_badlen_nclear", 64'(nclear), 64'd0);
      chk("idle_badlen_s_ready", 64'(s_ready), 64'd0);
      tick();

      // Back-to-back load at base 1
      do_start(6'd3, 5'd1);
      chk("t1_err_cleared", 64'(err), 64'd0);
      chk("t1_busy", 64'(busy), 64'd1);
      send_word(32'h00211020, 5'd1, 1'b1);
      send_word(32'h00221820, 5'd2, 1'b1);
      send_word(32'h00622022, 5'd3, 1'b1);
      end_load();

      // Illegal length in RUN, then s_valid while RUN must not write
      do_start(6'd33, 5'd0);
      chk("run_badlen_err", 64'(err), 64'd1);
      chk("run_badlen_nclear", 64'(nclear), 64'd1);
      chk("run_badlen_done", 64'(done), 64'd1);
      chk("run_badlen_busy", 64'(busy), 64'd0);
      s_valid = 1'b1;
      s_data  = 32'hDEADBEEF;
      tick();
      tick();
      s_valid = 1'b0;
      chk("run_s_ready", 64'(s_ready), 64'd0);
      chk("run_still_nclear", 64'(nclear), 64'd1);

      // Gapped stream 1,0,0,1
      do_start(6'd2, 5'd10);
      chk("t2_nclear_held", 64'(nclear), 64'd0);
      chk("t2_done_cleared", 64'(done), 64'd0);
      chk("t2_err_cleared", 64'(err), 64'd0);
      send_word(32'hA5A5_0001, 5'd10, 1'b1);
      s_valid = 1'b0;
      chk("t2_gap1_s_ready", 64'(s_ready), 64'd1);
      tick();
      chk("t2_gap2_s_ready", 64'(s_ready), 64'd1);
      tick();
      send_word(32'hA5A5_0002, 5'd11, 1'b1);
      end_load();

      // Address wrap
      do_start(6'd2, 5'd31);
      send_word(32'h1234_5678, 5'd31, 1'b1);
      send_word(32'h8765_4321, 5'd0, 1'b1);
      end_load();

      // Reset mid-load
      do_start(6'd3, 5'd4);
      send_word(32'hCAFE_0000, 5'd4, 1'b1);
      s_valid = 1'b0;
      @(negedge clk);
      #1;
      nRST = 1'b0;
      #1;
      chk_reset_vals("midrst");
      chk("midrst_write_seen", 64'(exp_q.size()), 64'd0);
      #2;
      nRST = 1'b1;
      tick();
      do_start(6'd3, 5'd4);
      send_word(32'hCAFE_0001, 5'd4, 1'b1);
      send_word(32'hCAFE_0002, 5'd5, 1'b1);
      send_word(32'hCAFE_0003, 5'd6, 1'b1);
      end_load();

`ifdef IMEM_BOOT_CHECKSUM_EN
      // Checksum match
      do_start(6'd2, 5'd0);
      send_word(32'h1, 5'd0, 1'b1);
      send_word(32'h2, 5'd1, 1'b1);
      send_word(32'h3, 5'd0, 1'b0);
      s_valid = 1'b0;
      chk("cs_ok_drain_busy", 64'(busy), 64'd1);
      tick();
      chk("cs_ok_nclear", 64'(nclear), 64'd1);
      chk("cs_ok_err", 64'(err), 64'd0);
      // Checksum mismatch
      do_start(6'd2, 5'd0);
      send_word(32'h1, 5'd0, 1'b1);
      send_word(32'h2, 5'd1, 1'b1);
      send_word(32'h4, 5'd0, 1'b0);
      s_valid = 1'b0;
      chk("cs_bad_err", 64'(err), 64'd1);
      chk("cs_bad_nclear", 64'(nclear), 64'd0);
      chk("cs_bad_busy", 64'(busy), 64'd0);
      chk("cs_bad_s_ready", 64'(s_ready), 64'd0);
      chk("cs_bad_done", 64'(done), 64'd0);
      tick();
      chk("cs_bad_stay_nclear", 64'(nclear), 64'd0);
`endif

      tick();
      tick();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
